// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared op encodings, FSM states and counter width for the cache request arbiter
package cache_arb_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Wide enough for the largest supported timeout (255)
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Walk every position starting at ptr with wrap-around; the first active one wins
    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - round-robin sharing of one cache host port with tagged responses and timeout
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_hit,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic [DATA_W-1:0]         cache_wdata,
    output logic                      cache_read,
    output logic                      cache_write,
    output logic                      cache_flush,
    input  logic [DATA_W-1:0]         cache_rdata,
    input  logic                      cache_hit,
    input  logic                      cache_ready
);

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    lat_id;
    logic [1:0]         lat_op;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [1:0]         sel_op;
    logic               expire;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt_vec),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_op = req_op[int'(gnt_idx) * 2 +: 2];
    // The last allowed BUSY cycle is the one entered with the counter at 1
    assign expire = (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grant pulse, and cache commands gated off in the cache_ready cycle
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        cache_flush = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any && !rst) begin
                    req_ready  = gnt_vec;
                    state_next = (sel_op == OP_RSVD) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cache_read  = (lat_op == OP_READ)  && !cache_ready;
                cache_write = (lat_op == OP_WRITE) && !cache_ready;
                cache_flush = (lat_op == OP_FLUSH) && !cache_ready;
                if (cache_ready || expire) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latch the granted request, run the timeout, build the response and advance the rr pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            lat_id      <= '0;
            lat_op      <= OP_READ;
            cnt         <= '0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_hit     <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        lat_id      <= gnt_idx;
                        lat_op      <= sel_op;
                        cache_addr  <= req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
                        cache_wdata <= req_wdata[int'(gnt_idx) * DATA_W +: DATA_W];
                        cnt         <= CNT_W'(TIMEOUT);
                        if (sel_op == OP_RSVD) begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= gnt_idx;
                            rsp_data  <= '0;
                            rsp_hit   <= 1'b0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cache_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= lat_id;
                        rsp_data  <= (lat_op == OP_READ) ? cache_rdata : '0;
                        rsp_hit   <= cache_hit;
                        rsp_err   <= 1'b0;
                    end else if (expire) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= lat_id;
                        rsp_data  <= '0;
                        rsp_hit   <= 1'b0;
                        rsp_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr <= (int'(lat_id) == NUM_REQ - 1) ? '0 : lat_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - self-checking bench with cache host model and arbiter reference model
module tb_cache_req_arbiter;
    import cache_arb_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_op;
    logic [32*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_hit;
    logic            rsp_err;
    logic [31:0]     cache_addr;
    logic [31:0]     cache_wdata;
    logic            cache_read;
    logic            cache_write;
    logic            cache_flush;
    logic [31:0]     cache_rdata;
    logic            cache_hit;
    logic            cache_ready;

    cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_read(cache_read), .cache_write(cache_write), .cache_flush(cache_flush),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit), .cache_ready(cache_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int viol   = 0;
    int flush_hi = 0;
    int cmd_hi   = 0;
    int outstanding = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- cache host model: direct-mapped, 16 lines, write-through/allocate
    bit          withhold = 1'b0;
    logic [31:0] h_mem [logic [31:0]];
    logic        h_vld [16];
    logic [25:0] h_tag [16];
    logic [31:0] h_dat [16];
    bit          h_busy = 1'b0;
    int          h_rem = 0;
    logic [1:0]  h_op;
    logic [31:0] h_a, h_d;
    bit          h_hit;

    function automatic logic [31:0] h_rd(input logic [31:0] a);
        return h_mem.exists(a) ? h_mem[a] : a + 32'h15;
    endfunction

    initial begin
        int idx;
        logic [31:0] v;
        cache_ready = 1'b0;
        cache_rdata = '0;
        cache_hit   = 1'b0;
        for (int i = 0; i < 16; i++) h_vld[i] = 1'b0;
        forever begin
            @(posedge clk); #1;
            cache_rdata = $urandom;
            cache_hit   = 1'($urandom_range(0, 1));
            if (rst) begin
                h_busy = 1'b0;
                cache_ready = 1'b0;
            end else if (h_busy) begin
                if (!(cache_read | cache_write | cache_flush)) begin
                    h_busy = 1'b0;
                    cache_ready = 1'b0;
                end else begin
                    if (cache_addr !== h_a || cache_wdata !== h_d) viol++;
                    if (!withhold && h_rem == 0) begin
                        idx = int'(h_a[5:2]);
                        cache_ready = 1'b1;
                        h_busy = 1'b0;
                        if (h_op == OP_READ) begin
                            v = h_hit ? h_dat[idx] : h_rd(h_a);
                            h_vld[idx] = 1'b1; h_tag[idx] = h_a[31:6]; h_dat[idx] = v;
                            cache_rdata = v;
                            cache_hit = h_hit;
                        end else if (h_op == OP_WRITE) begin
                            h_mem[h_a] = h_d;
                            h_vld[idx] = 1'b1; h_tag[idx] = h_a[31:6]; h_dat[idx] = h_d;
                            cache_hit = h_hit;
                        end else begin
                            for (int i = 0; i < 16; i++) h_vld[i] = 1'b0;
                            cache_hit = 1'b0;
                        end
                    end else begin
                        if (h_rem > 0) h_rem--;
                        cache_ready = 1'b0;
                    end
                end
            end else begin
                cache_ready = 1'b0;
                if (cache_read | cache_write | cache_flush) begin
                    if ($countones({cache_read, cache_write, cache_flush}) != 1) viol++;
                    h_op = cache_read ? OP_READ : (cache_write ? OP_WRITE : OP_FLUSH);
                    h_a = cache_addr;
                    h_d = cache_wdata;
                    idx = int'(cache_addr[5:2]);
                    h_hit = (h_op != OP_FLUSH) && h_vld[idx] && (h_tag[idx] == cache_addr[31:6]);
                    h_rem = (h_op == OP_FLUSH) ? 0 : (h_hit ? 1 : 2);
                    h_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- protocol monitor: one-hot grants, at most one op in flight
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
            end else begin
                if (!$onehot0(req_ready)) viol++;
                if (rsp_valid) outstanding--;
                if (req_ready != '0) outstanding++;
                if (outstanding > 1 || outstanding < 0) viol++;
                if ((cache_read | cache_write | cache_flush) && outstanding == 0) viol++;
                if (cache_flush) flush_hi++;
                if (cache_read | cache_write | cache_flush) cmd_hi++;
            end
        end
    end

    // ---------------- reference model: rr pointer and memory contents
    int          m_ptr = 0;
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a + 32'h15;
    endfunction

    function automatic int m_pick(input logic [N-1:0] pend);
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic run_op(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          output int g, output int r, output logic [1:0] rid, output logic [31:0] rdata,
                          output logic rhit, output logic rerr, output logic [2:0] rcmd);
        bit got;
        req_valid[id] = 1'b1;
        req_op[2*id +: 2] = op;
        req_addr[32*id +: 32] = a;
        req_wdata[32*id +: 32] = d;
        got = 1'b0; g = -1; r = -1;
        rid = 'x; rdata = 'x; rhit = 'x; rerr = 'x; rcmd = 'x;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin got = 1'b1; g = cyc; end
            @(posedge clk); #1;
        end
        req_valid[id] = 1'b0;
        chk("grant_seen", 64'(got), 64'd1);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; r = cyc;
                rid = rsp_id; rdata = rsp_data; rhit = rsp_hit; rerr = rsp_err;
                rcmd = {cache_read, cache_write, cache_flush};
            end
            @(posedge clk); #1;
        end
        chk("rsp_seen", 64'(got), 64'd1);
        m_ptr = (id + 1) % N;
        if (op == OP_WRITE) ref_mem[a] = d;
    endtask

    task automatic check_op(input string tag, input int id, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] d, input int exp_lat, input bit chk_hit, input bit exp_hit);
        int g, r;
        logic [1:0] rid;
        logic [31:0] rdata, exp_data;
        logic rhit, rerr, exp_err;
        logic [2:0] rcmd;
        exp_err  = (op == OP_RSVD);
        exp_data = (op == OP_READ) ? ref_rd(a) : 32'h0;
        run_op(id, op, a, d, g, r, rid, rdata, rhit, rerr, rcmd);
        chk({tag, "_id"}, 64'(rid), 64'(id));
        chk({tag, "_data"}, 64'(rdata), 64'(exp_data));
        chk({tag, "_err"}, 64'(rerr), 64'(exp_err));
        chk({tag, "_cmd_in_resp"}, 64'(rcmd), 64'd0);
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(r - g), 64'(exp_lat));
        if (chk_hit) chk({tag, "_hit"}, 64'(rhit), 64'(exp_hit));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1);
    end

    initial begin
        int g, r, n_rsp, pend_id, exp_g, seen, op_sel, id;
        logic [1:0] rid, op;
        logic [31:0] rdata, a, d;
        logic rhit, rerr;
        logic [2:0] rcmd;
        logic [N-1:0] onehot;
        logic [31:0] rr_a [N];
        bit got;

        rst = 1'b1;
        req_valid = '1;
        req_op = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ctl", 64'({rsp_valid, rsp_id, rsp_hit, rsp_err, cache_read, cache_write, cache_flush}), 64'd0);
        chk("rst_data", {rsp_data, cache_addr}, 64'd0);
        chk("rst_wdata", 64'(cache_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;

        check_op("rd_miss", 0, OP_READ, 32'h0000_0010, 32'h0, 5, 1'b1, 1'b0);
        chk("rd_miss_value", 64'(ref_rd(32'h10)), 64'h25);
        check_op("wr_hit", 1, OP_WRITE, 32'h0000_0010, 32'hCAFE_F00D, 4, 1'b1, 1'b1);
        check_op("rd_hit", 1, OP_READ, 32'h0000_0010, 32'h0, 4, 1'b1, 1'b1);
        check_op("rd_prep", 3, OP_READ, 32'h0000_0020, 32'h0, 5, 1'b1, 1'b0);

        // all four requesters hold reads; five grants must follow the rotating order
        for (int i = 0; i < N; i++) begin
            rr_a[i] = 32'h200 + 32'(i * 4);
            req_valid[i] = 1'b1;
            req_op[2*i +: 2] = OP_READ;
            req_addr[32*i +: 32] = rr_a[i];
        end
        n_rsp = 0;
        pend_id = 0;
        for (int c = 0; c < 300 && n_rsp < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                exp_g = m_pick(req_valid);
                onehot = '0;
                onehot[exp_g] = 1'b1;
                chk("rr_grant", 64'(req_ready), 64'(onehot));
                pend_id = exp_g;
            end
            if (rsp_valid) begin
                chk("rr_rsp_id", 64'(rsp_id), 64'(pend_id));
                chk("rr_rsp_data", 64'(rsp_data), 64'(ref_rd(rr_a[pend_id])));
                m_ptr = (pend_id + 1) % N;
                n_rsp++;
            end
            @(posedge clk); #1;
            if (n_rsp == 5) req_valid = '0;
        end
        req_valid = '0;
        chk("rr_count", 64'(n_rsp), 64'd5);

        flush_hi = 0;
        check_op("flush", 2, OP_FLUSH, 32'h0, 32'h0, 3, 1'b1, 1'b0);
        chk("flush_high_cycles", 64'(flush_hi), 64'd1);
        check_op("rd_after_flush", 1, OP_READ, 32'h0000_0010, 32'h0, 5, 1'b1, 1'b0);

        withhold = 1'b1;
        run_op(3, OP_READ, 32'h0000_0040, 32'h0, g, r, rid, rdata, rhit, rerr, rcmd);
        withhold = 1'b0;
        chk("timeout_id", 64'(rid), 64'd3);
        chk("timeout_err", 64'(rerr), 64'd1);
        chk("timeout_data", 64'(rdata), 64'd0);
        chk("timeout_latency", 64'(r - g), 64'd16);
        chk("timeout_cmd", 64'(rcmd), 64'd0);

        cmd_hi = 0;
        check_op("rsvd", 0, OP_RSVD, 32'h0000_0080, 32'h0, 1, 1'b1, 1'b0);
        chk("rsvd_no_cmd", 64'(cmd_hi), 64'd0);

        // reset in the middle of a miss
        req_valid[2] = 1'b1;
        req_op[5:4] = OP_READ;
        req_addr[95:64] = 32'h0000_1000;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (req_ready[2]) got = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[2] = 1'b0;
        chk("rstb_grant", 64'(got), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstb_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_hit, rsp_err, cache_read, cache_write, cache_flush}), 64'd0);
        chk("rstb_data", {rsp_data, cache_addr}, 64'd0);
        chk("rstb_wdata", 64'(cache_wdata), 64'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        @(posedge clk); #1;
        chk("rstb_no_rsp", 64'(seen), 64'd0);
        m_ptr = 0;
        check_op("after_rst", 2, OP_READ, 32'h0000_0010, 32'h0, -1, 1'b0, 1'b0);

        // randomized single requests against the reference memory
        for (int t = 0; t < 30; t++) begin
            id = int'($urandom_range(0, N - 1));
            op_sel = int'($urandom_range(0, 9));
            op = (op_sel < 5) ? OP_READ : (op_sel < 8) ? OP_WRITE : (op_sel == 8) ? OP_FLUSH : OP_RSVD;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            d = $urandom;
            check_op("rand", id, op, a, d, -1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        chk("protocol_violations", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
